mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max MEM cycles without mem_ack before error; must be ≥1.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clock in 1, rising-edge clock; reset in 1, async active-high reset.
REQ-005 if_valid in 1, fetch request; if_addr in ADDR_W, fetch address; if_ready out 1, fetch accepted.
REQ-006 if_rvalid out 1, fetch response pulse; if_rdata out DATA_W, fetch read data; if_err out 1, fetch timeout flag.
REQ-007 d_valid in 1, data request; d_we in 1, store when 1; d_addr in ADDR_W, data address; d_wdata in DATA_W, store data; d_ready out 1, data accepted.
REQ-008 d_rvalid out 1, data response pulse; d_rdata out DATA_W, load data; d_err out 1, data timeout flag.
REQ-009 Memory side: ADDR out ADDR_W; DOUT out DATA_W; W out 1, write strobe; mem_req out 1; DIN in DATA_W; mem_ack in 1.
REQ-010 busy out 1, high in any state other than IDLE.

Function
REQ-011 SHALL use states IDLE, MEM and RESP; one transaction is outstanding at a time.
REQ-012 In IDLE, the arbiter SHALL select one valid requester; x_ready = x_valid & selected is combinational, and the payload is latched on that edge; next state MEM.
REQ-013 Requesters SHALL hold valid and payload stable until ready; ready SHALL be 0 outside IDLE.
REQ-014 In MEM, mem_req=1, ADDR/DOUT/W SHALL come from latched registers and stay stable; W = latched we (0 for fetch); DOUT = 0 for fetch.
REQ-015 mem_ack=1 in MEM: DIN latched to the owner's rdata register; next RESP with err=0.
REQ-016 Timeout counter SHALL clear on entering MEM and increment each MEM cycle without ack; at count==TIMEOUT: next RESP with err=1 and rdata=0.
REQ-017 If mem_ack and timeout occur in the same cycle, ack SHALL win.
REQ-018 RESP SHALL last one cycle: owner's rvalid=1 (with err); next IDLE.
REQ-019 Minimum latency: accept at cycle 0, mem_req cycles 1..k, rvalid at cycle k+1; throughput is at most one transaction per 3 cycles.
REQ-020 mem_ack outside MEM SHALL be ignored.
REQ-021 rdata outputs SHALL hold their last value until the next response to the same requester.
REQ-022 Default arbitration SHALL be fixed priority: data over fetch.

Reset
REQ-023 Reset SHALL asynchronously force state IDLE and clear: counter, latched payload, ADDR, DOUT, W, mem_req, all ready/rvalid/err, rdata, busy, and last_grant=fetch.
REQ-024 Reset mid-transaction SHALL drop it silently: no rvalid after reset; the memory sees mem_req fall.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not recorded in last_grant; update last_grant at each accept.
REQ-026 Macro absent: fixed priority per REQ-022; last_grant register SHALL not exist.

Structure
REQ-027 Shared package proc_pkg SHALL hold the state enum (IDLE/MEM/RESP), requester ID constants (REQ_FETCH=0, REQ_DATA=1) and default widths.
REQ-028 Single module; no sub-module required. The counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-029 Fetch only, if_addr=0x100, mem_ack in 1st MEM cycle, DIN=0xDEADBEEF -> ADDR=0x100, W=0, if_rvalid 2 cycles after accept, if_rdata=0xDEADBEEF, if_err=0.
REQ-030 Both valid in IDLE; d_we=1, d_addr=0x200, d_wdata=0x55 -> d_ready first, W=1, DOUT=0x55; fetch accepted in the IDLE following RESP.
REQ-031 With MEM_ARB_ROUND_ROBIN_EN, both held valid for 4 transactions -> grant order data, fetch, data, fetch; without it -> data x4.
REQ-032 mem_ack never asserted, TIMEOUT=15 -> mem_req high 16 cycles, then d_rvalid=1, d_err=1, d_rdata=0; mem_ack on cycle 16 together with timeout -> err=0.
REQ-033 reset asserted in 2nd MEM cycle -> outputs 0 immediately (asynchronously), no rvalid afterwards; a new request completes normally.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the memory port arbiter.
// No logic: state encoding, requester IDs and default widths only.
// Imported by mem_port_arbiter and its testbench.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory port.
// Latency: accept at cycle 0, mem_req cycles 1..k, rvalid at k+1 (>= 3 cycles per transaction).
// Backpressure: ready only in IDLE; memory stalls via mem_ack, bounded by TIMEOUT (error response).
// Option: define MEM_ARB_ROUND_ROBIN_EN for alternating grants on contention (default: data wins).
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  // fetch port
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // data port
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // memory port
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W,
  output logic              mem_req,
  input  logic [DATA_W-1:0] DIN,
  input  logic              mem_ack,
  // status
  output logic              busy
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic idle_ok;
  logic pick_data;
  logic acc_f;
  logic acc_d;

  // Choose a requester while idle; ready is withheld during reset so nothing is accepted then.
  always_comb begin
    pick_data = d_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (d_valid && if_valid) begin
      pick_data = (last_grant_q == REQ_FETCH);
    end
`endif
    idle_ok = (state_q == IDLE) && !reset;
    acc_d   = idle_ok && d_valid && pick_data;
    acc_f   = idle_ok && if_valid && !pick_data;
  end

  // Next-state and register updates for the IDLE -> MEM -> RESP transaction cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc_d) begin
          owner_d = REQ_DATA;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
          cnt_d   = '0;
          state_d = MEM;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = REQ_DATA;
`endif
        end else if (acc_f) begin
          owner_d = REQ_FETCH;
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = MEM;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = REQ_FETCH;
`endif
        end
      end
      MEM: begin
        // An ack arriving in the final allowed cycle still counts as success.
        if (mem_ack) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (owner_q == REQ_DATA) d_rdata_d  = DIN;
          else                     if_rdata_d = DIN;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = RESP;
          if (owner_q == REQ_DATA) d_rdata_d  = '0;
          else                     if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= REQ_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_FETCH;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_ready  = acc_f;
  assign d_ready   = acc_d;
  assign mem_req   = (state_q == MEM);
  assign W         = mem_req && we_q;
  assign ADDR      = addr_q;
  assign DOUT      = wdata_q;
  assign if_rvalid = (state_q == RESP) && (owner_q == REQ_FETCH);
  assign d_rvalid  = (state_q == RESP) && (owner_q == REQ_DATA);
  assign if_err    = if_rvalid && err_q;
  assign d_err     = d_rvalid && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers, memory responder, response/grant monitor.
// Directed cases (fetch, contention, timeout edge, mid-transaction reset) then random traffic.
// Expected behaviour comes from a transaction-level model of grant, latency and timeout rules.
module tb_mem_port_arbiter;
  import proc_pkg::*;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TMO    = 15;
  localparam int NO_ACK = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_valid, if_ready, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_valid, d_we, d_ready, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DOUT, DIN;
  logic          W, mem_req, mem_ack, busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ADDR(ADDR), .DOUT(DOUT), .W(W), .mem_req(mem_req), .DIN(DIN), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          owner;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            gap;
    int            acc;
  } txn_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] rdata;
    logic          err;
    int            at;
  } resp_t;

  typedef struct {
    int            delay;
    logic [DW-1:0] din;
    bit            use_din;
  } force_t;

  txn_t   fq[$];
  txn_t   dq[$];
  txn_t   mem_q[$];
  resp_t  resp_q[$];
  force_t force_q[$];

  bit            f_pend = 0;
  bit            d_pend = 0;
  bit            model_idle = 1;
  logic          model_last = REQ_FETCH;
  logic [DW-1:0] exp_if_rd = '0;
  logic [DW-1:0] exp_d_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic owner, input logic [AW-1:0] addr, input logic we,
                              input logic [DW-1:0] wdata, input int gap);
    txn_t t;
    t.owner = owner;
    t.addr  = addr;
    t.we    = (owner == REQ_DATA) ? we : 1'b0;
    t.wdata = (owner == REQ_DATA) ? wdata : '0;
    t.gap   = gap;
    t.acc   = 0;
    return t;
  endfunction

  function automatic force_t mkf(input int delay, input logic [DW-1:0] din, input bit use_din);
    force_t f;
    f.delay   = delay;
    f.din     = din;
    f.use_din = use_din;
    return f;
  endfunction

  // Requester drivers: present queued requests, hold them until the handshake.
  initial begin
    txn_t fc, dc;
    if_valid = 0; if_addr = '0;
    d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        f_pend = 0; d_pend = 0; if_valid = 0; d_valid = 0;
        continue;
      end
      if (!f_pend) begin
        if_valid = 0;
        if (fq.size() > 0) begin
          if (fq[0].gap > 0) fq[0].gap = fq[0].gap - 1;
          else begin
            fc = fq.pop_front();
            f_pend = 1; if_valid = 1; if_addr = fc.addr;
          end
        end
      end
      if (!d_pend) begin
        d_valid = 0;
        if (dq.size() > 0) begin
          if (dq[0].gap > 0) dq[0].gap = dq[0].gap - 1;
          else begin
            dc = dq.pop_front();
            d_pend = 1; d_valid = 1; d_addr = dc.addr; d_we = dc.we; d_wdata = dc.wdata;
          end
        end
      end
      #3;
      if (f_pend && if_ready) begin fc.acc = cyc; mem_q.push_back(fc); f_pend = 0; end
      if (d_pend && d_ready)  begin dc.acc = cyc; mem_q.push_back(dc); d_pend = 0; end
    end
  end

  // Memory responder: checks each memory access and predicts the response it causes.
  initial begin
    txn_t          cur;
    force_t        fc;
    resp_t         r;
    bit            in_txn = 0;
    int            n = 0;
    int            dly = 0;
    logic [DW-1:0] din;
    mem_ack = 0; DIN = '0;
    forever begin
      @(negedge clock);
      mem_ack = ($urandom_range(0, 3) == 0);
      DIN = $urandom;
      if (reset) begin in_txn = 0; continue; end
      if (mem_req) begin
        if (!in_txn) begin
          if (mem_q.size() == 0) begin
            chk("mem_req_spurious", 64'(1), 64'(0));
            mem_ack = 0;
            continue;
          end
          cur = mem_q.pop_front();
          in_txn = 1; n = 0;
          chk("mem_start_cycle", 64'(cyc), 64'(cur.acc + 1));
          if (force_q.size() > 0) begin
            fc = force_q.pop_front();
            dly = fc.delay;
            din = fc.use_din ? fc.din : DW'($urandom);
          end else begin
            dly = $urandom_range(0, 19);
            din = $urandom;
          end
        end
        chk("mem_addr", 64'(ADDR), 64'(cur.addr));
        chk("mem_w", 64'(W), 64'(cur.we));
        chk("mem_dout", 64'(DOUT), 64'(cur.wdata));
        n++;
        mem_ack = 0;
        if (dly == n - 1) begin
          mem_ack = 1; DIN = din;
          r.owner = cur.owner; r.rdata = din; r.err = 1'b0; r.at = cyc + 1;
          resp_q.push_back(r);
          in_txn = 0;
        end else if (n == TMO + 1) begin
          r.owner = cur.owner; r.rdata = '0; r.err = 1'b1; r.at = cyc + 1;
          resp_q.push_back(r);
          in_txn = 0;
        end
      end else if (in_txn) begin
        chk("mem_req_dropped", 64'(0), 64'(1));
        in_txn = 0;
      end
    end
  end

  // Monitor: responses, rdata hold, busy and grant decisions against the model.
  initial begin
    resp_t r;
    bit    resp_now;
    bit    g_d;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        model_idle = 1; model_last = REQ_FETCH; exp_if_rd = '0; exp_d_rd = '0;
        continue;
      end
      resp_now = 0;
      if (resp_q.size() > 0 && resp_q[0].at == cyc) begin
        r = resp_q.pop_front();
        resp_now = 1;
        if (r.owner == REQ_DATA) begin
          chk("d_resp_valid", 64'({d_rvalid, if_rvalid}), 64'(2'b10));
          chk("d_err", 64'({d_err, if_err}), 64'({r.err, 1'b0}));
          exp_d_rd = r.rdata;
        end else begin
          chk("if_resp_valid", 64'({d_rvalid, if_rvalid}), 64'(2'b01));
          chk("if_err", 64'({if_err, d_err}), 64'({r.err, 1'b0}));
          exp_if_rd = r.rdata;
        end
      end else begin
        chk("no_resp", 64'({if_rvalid, d_rvalid, if_err, d_err}), 64'(0));
      end
      chk("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
      chk("d_rdata", 64'(d_rdata), 64'(exp_d_rd));
      chk("busy", 64'(busy), 64'(!model_idle));
      if (model_idle && (if_valid || d_valid)) begin
        g_d = d_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (d_valid && if_valid) g_d = (model_last == REQ_FETCH);
`endif
        chk("grant", 64'({d_ready, if_ready}), g_d ? 64'(2'b10) : 64'(2'b01));
        model_idle = 0;
        model_last = g_d ? REQ_DATA : REQ_FETCH;
      end else begin
        chk("ready_low", 64'({d_ready, if_ready}), 64'(0));
      end
      if (resp_now) model_idle = 1;
    end
  end

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock); #1;
      if (fq.size() == 0 && dq.size() == 0 && !f_pend && !d_pend && mem_q.size() == 0 &&
          resp_q.size() == 0 && model_idle && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) $display("FAIL %s: drain did not finish, got busy, expected idle", name);
    chk("drain_done", 64'(done), 64'(1));
  endtask

  initial begin
    int  n;
    bit  own;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ctrl", 64'({mem_req, busy, W, if_ready, d_ready, if_rvalid, d_rvalid, if_err, d_err}), 64'(0));
    chk("rst_bus", 64'({ADDR, DOUT}), 64'(0));
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    reset = 0;

    // single fetch, immediate ack
    force_q.push_back(mkf(0, 32'hDEADBEEF, 1));
    fq.push_back(mk(REQ_FETCH, 32'h100, 0, 0, 0));
    wait_idle("fetch_only");

    // contention: store wins, fetch follows
    force_q.push_back(mkf(2, 0, 0));
    force_q.push_back(mkf(1, 0, 0));
    dq.push_back(mk(REQ_DATA, 32'h200, 1, 32'h55, 0));
    fq.push_back(mk(REQ_FETCH, 32'h300, 0, 0, 0));
    wait_idle("contention");

    // full timeout, then ack landing on the last allowed cycle
    force_q.push_back(mkf(NO_ACK, 0, 0));
    dq.push_back(mk(REQ_DATA, 32'h400, 0, 32'h9, 0));
    force_q.push_back(mkf(TMO, 32'hCAFE0001, 1));
    dq.push_back(mk(REQ_DATA, 32'h404, 0, 32'h0, 0));
    wait_idle("timeout");

    // sustained contention over four transactions per port
    for (int i = 0; i < 8; i++) force_q.push_back(mkf(0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      dq.push_back(mk(REQ_DATA, AW'($urandom), 1, DW'($urandom), 0));
      fq.push_back(mk(REQ_FETCH, AW'($urandom), 0, 0, 0));
    end
    wait_idle("sustained");

    // reset in the second memory cycle of a stalled store
    force_q.push_back(mkf(NO_ACK, 0, 0));
    dq.push_back(mk(REQ_DATA, 32'h500, 1, 32'h77, 0));
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(posedge clock); #1;
      if (mem_req) n++;
    end
    chk("rst_reach_mem", 64'(n), 64'(2));
    reset = 1;
    #1;
    chk("rst_async_ctrl", 64'({mem_req, busy, W, d_ready, if_ready, d_rvalid, if_rvalid}), 64'(0));
    chk("rst_async_bus", 64'({ADDR, DOUT}), 64'(0));
    chk("rst_async_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    mem_q.delete(); resp_q.delete(); force_q.delete(); fq.delete(); dq.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    repeat (5) @(posedge clock);
    force_q.push_back(mkf(1, 0, 0));
    fq.push_back(mk(REQ_FETCH, 32'h600, 0, 0, 0));
    wait_idle("after_reset");

    // random traffic, random memory latency including timeouts
    for (int i = 0; i < 300; i++) begin
      own = 1'($urandom_range(0, 1));
      if (own == REQ_DATA)
        dq.push_back(mk(REQ_DATA, AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 3)));
      else
        fq.push_back(mk(REQ_FETCH, AW'($urandom), 0, 0, $urandom_range(0, 3)));
    end
    wait_idle("random");

    chk("mem_q_empty", 64'(mem_q.size()), 64'(0));
    chk("resp_q_empty", 64'(resp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
